// File: rtl/ws_pkg.sv
// rtl/ws_pkg.sv - shared types, timing defaults and helpers for the LED chain transmitter
// Purpose: pixel type, FSM state encoding, 100 MHz timing defaults, counter sizing.
// Ports: none (package).
package ws_pkg;

    localparam int PIXEL_BITS = 24;

    // Defaults for a 100 MHz clock.
    localparam int DEF_T0H_CYCLES    = 40;
    localparam int DEF_T1H_CYCLES    = 80;
    localparam int DEF_TBIT_CYCLES   = 125;
    localparam int DEF_TRESET_CYCLES = 5000;

    typedef logic [PIXEL_BITS-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BIT   = 2'd1,
        LATCH = 2'd2
    } tx_state_t;

    // One counter serves both bit timing and the latch gap, so it is sized for the larger.
    function automatic int cnt_width(input int tbit, input int treset);
        int m;
        m = (tbit > treset) ? tbit : treset;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ws_bit_encoder.sv
// rtl/ws_bit_encoder.sv - times one NRZ pulse-width bit on the serial line
// Purpose: on i_start, drive o_serial high for T1H/T0H cycles (bit 1/0) within a
//          TBIT-cycle period; o_bit_end marks the last cycle of the period.
// Ports: i_clk, i_rst (sync, active high), i_start (begin a bit, wins over end),
//        i_bit (value latched on i_start), o_serial (registered line),
//        o_bit_end (combinational, last cycle of the current bit).
module ws_bit_encoder
    import ws_pkg::*;
#(
    parameter int T0H_CYCLES  = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES  = DEF_T1H_CYCLES,
    parameter int TBIT_CYCLES = DEF_TBIT_CYCLES,
    parameter int CNT_W       = 7
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_bit,
    output logic o_serial,
    output logic o_bit_end
);

    localparam logic [CNT_W-1:0] T0H_C  = CNT_W'(T0H_CYCLES);
    localparam logic [CNT_W-1:0] T1H_C  = CNT_W'(T1H_CYCLES);
    localparam logic [CNT_W-1:0] TEND_C = CNT_W'(TBIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_q, bit_d;
    logic             active_q, active_d;
    logic             serial_q, serial_d;
    logic [CNT_W-1:0] thigh;

    assign thigh     = bit_q ? T1H_C : T0H_C;
    assign o_bit_end = active_q && (cnt_q == TEND_C);
    assign o_serial  = serial_q;

    // serial_d is computed from the next count so the registered line equals (cnt < THIGH).
    always_comb begin
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        active_d = active_q;
        serial_d = serial_q;
        if (i_start) begin
            cnt_d    = '0;
            bit_d    = i_bit;
            active_d = 1'b1;
            serial_d = 1'b1;
        end else if (o_bit_end) begin
            cnt_d    = '0;
            active_d = 1'b0;
            serial_d = 1'b0;
        end else if (active_q) begin
            cnt_d    = cnt_q + CNT_W'(1);
            serial_d = (cnt_d < thigh);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
            serial_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            serial_q <= serial_d;
        end
    end

endmodule

// File: rtl/ws_pixel_tx.sv
// rtl/ws_pixel_tx.sv - LED chain transmitter: pixel handshake in, NRZ pulse-width line out
// Purpose: one-entry holding register, 24-bit MSB-first shifter, IDLE/BIT/LATCH FSM.
// Ports: i_clk, i_rst (sync, active high), i_pixel/i_last/i_valid/o_ready (pixel input
//        handshake), o_serial (registered line), o_busy (not IDLE), o_underrun (pulse:
//        frame ended without i_last), o_frame_done (pulse: latch gap finished).
module ws_pixel_tx
    import ws_pkg::*;
#(
    parameter int T0H_CYCLES    = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES    = DEF_T1H_CYCLES,
    parameter int TBIT_CYCLES   = DEF_TBIT_CYCLES,
    parameter int TRESET_CYCLES = DEF_TRESET_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_pixel,
    input  logic        i_last,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_serial,
    output logic        o_busy,
    output logic        o_underrun,
    output logic        o_frame_done
);

    localparam int               CNT_W     = cnt_width(TBIT_CYCLES, TRESET_CYCLES);
    localparam logic [CNT_W-1:0] LATCH_END = CNT_W'(TRESET_CYCLES - 1);
    localparam logic [4:0]       FIRST_IDX = 5'(PIXEL_BITS - 1);

    if (!(T0H_CYCLES >= 1 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < TBIT_CYCLES
          && TRESET_CYCLES >= 1)) begin : g_bad_timing
        $error("ws_pixel_tx: illegal timing parameters");
    end

    tx_state_t        state_q, state_d;
    pixel_t           hold_q, shift_q;
    logic             hold_last_q, hold_v_q, last_q;
    logic [4:0]       idx_q;
    logic [CNT_W-1:0] lcnt_q;
    logic             underrun_q, underrun_d;
    logic             frame_done_q, frame_done_d;
    logic             load, shift, enc_start, enc_bit, bit_end;

    assign o_ready      = !hold_v_q;
    assign o_underrun   = underrun_q;
    assign o_frame_done = frame_done_q;
    assign enc_start    = load || shift;
    // A fresh load starts at the held word's MSB; a shift starts at the next bit down.
    assign enc_bit      = load ? hold_q[PIXEL_BITS-1] : shift_q[PIXEL_BITS-2];

    ws_bit_encoder #(
        .T0H_CYCLES (T0H_CYCLES),
        .T1H_CYCLES (T1H_CYCLES),
        .TBIT_CYCLES(TBIT_CYCLES),
        .CNT_W      (CNT_W)
    ) u_enc (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (enc_start),
        .i_bit    (enc_bit),
        .o_serial (o_serial),
        .o_bit_end(bit_end)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hold_v_q) state_d = BIT;
            BIT:     if (bit_end && idx_q == '0 && (last_q || !hold_v_q)) state_d = LATCH;
            LATCH:   if (lcnt_q == LATCH_END) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and datapath controls.
    always_comb begin
        load         = 1'b0;
        shift        = 1'b0;
        underrun_d   = 1'b0;
        frame_done_d = 1'b0;
        o_busy       = (state_q != IDLE);
        unique case (state_q)
            IDLE: load = hold_v_q;
            BIT: begin
                if (bit_end) begin
                    if (idx_q != '0)  shift      = 1'b1;
                    else if (last_q)  shift      = 1'b0;
                    else if (hold_v_q) load      = 1'b1;
                    else              underrun_d = 1'b1;
                end
            end
            LATCH:   frame_done_d = (lcnt_q == LATCH_END);
            default: ;
        endcase
    end

    // Holding register; a same-cycle accept overrides the clear from a transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_v_q    <= 1'b0;
        end else begin
            if (load) hold_v_q <= 1'b0;
            if (i_valid && o_ready) begin
                hold_q      <= i_pixel;
                hold_last_q <= i_last;
                hold_v_q    <= 1'b1;
            end
        end
    end

    // Shifter, bit index, latch counter and registered pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shift_q      <= '0;
            last_q       <= 1'b0;
            idx_q        <= '0;
            lcnt_q       <= '0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (load) begin
                shift_q <= hold_q;
                last_q  <= hold_last_q;
                idx_q   <= FIRST_IDX;
            end else if (shift) begin
                shift_q <= shift_q << 1;
                idx_q   <= idx_q - 5'd1;
            end
            lcnt_q       <= (state_q == LATCH) ? lcnt_q + CNT_W'(1) : '0;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: doc/ws_pixel_tx.md
Name: ws_pixel_tx

Overview:
- Transmitter end of the single-wire LED chain protocol. Consumes 24-bit pixel words over a valid/ready handshake and drives the NRZ pulse-width serial line that top_led receives on i_serial.
- Pixels are sent MSB first, back to back. A frame ends with a low latch gap.
- Sits between the pixel source (pattern generator or host bridge) and the first LED (or top_led instance) in the chain.

Parameters:
- T0H_CYCLES, 40, clock cycles o_serial is high for a '0' bit.
- T1H_CYCLES, 80, clock cycles o_serial is high for a '1' bit.
- TBIT_CYCLES, 125, total clock cycles per bit period.
- TRESET_CYCLES, 5000, clock cycles o_serial is held low for the frame latch gap.
- Defaults assume a 100 MHz clock. Legal configurations satisfy 1 <= T0H_CYCLES < T1H_CYCLES < TBIT_CYCLES and TRESET_CYCLES >= 1; elaboration fails otherwise.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active high
- i_pixel  in  24  pixel word; bit 23 is transmitted first
- i_last  in  1  qualifies i_pixel as the final pixel of the frame
- i_valid  in  1  i_pixel and i_last are valid
- o_ready  out  1  holding register empty; transfer occurs when i_valid && o_ready at a rising edge
- o_serial  out  1  encoded line output, registered
- o_busy  out  1  high in any state other than IDLE
- o_underrun  out  1  single-cycle pulse: a frame ended without i_last
- o_frame_done  out  1  single-cycle pulse at the end of the latch gap

Behaviour:
- Reset: synchronous, active high. All outputs and state clear on the next edge: o_serial=0, o_busy=0, o_underrun=0, o_frame_done=0, holding register empty (o_ready=1), FSM=IDLE.
- Reset mid-bit truncates the bit on the wire. No recovery pulse is generated. The receiver recovers on the next latch gap.
- Holding register (one entry): o_ready = !hold_v.
  - On acceptance, latch pixel and last, and set hold_v.
  - hold_v clears when the word moves into the shifter.
  - Acceptance and transfer in the same cycle are legal. The new word is kept and hold_v stays 1.
- FSM states: IDLE, BIT, LATCH.
- IDLE: when hold_v=1, load the shifter from the holding register, bit index 23, cnt=0, drive o_serial=1, go to BIT.
  - Latency: o_serial rises on the edge after the acceptance edge.
- BIT: cnt counts 0..TBIT_CYCLES-1.
  - o_serial=1 while cnt < THIGH, else 0. THIGH is T1H_CYCLES if the current bit is 1, otherwise T0H_CYCLES.
  - The output is registered, so each high pulse is exactly THIGH cycles and each bit period is exactly TBIT_CYCLES cycles.
- At cnt == TBIT_CYCLES-1, decide what follows:
  - Bit index > 0: shift, decrement the index, cnt=0. The next bit starts on the next cycle with no gap.
  - Index 0 and the current pixel's last flag is set: go to LATCH, cnt=0.
  - Index 0, not last, hold_v=1: load the next pixel seamlessly. There is no idle cycle between pixels.
  - Index 0, not last, hold_v=0: pulse o_underrun for one cycle, go to LATCH. The partial frame is latched by the chain.
- LATCH: o_serial=0 for exactly TRESET_CYCLES cycles, then pulse o_frame_done for one cycle and go to IDLE.
  - The holding register may accept during LATCH. Transmission waits for IDLE.
- Counter width is clog2(max(TBIT_CYCLES, TRESET_CYCLES)). Bit index is 5 bits. No wrap-around is reachable.
- Transmit time for N pixels: 24*N*TBIT_CYCLES + TRESET_CYCLES cycles of line activity.

Decomposition:
- Shared package ws_pkg holds:
  - pixel_t (logic [23:0])
  - tx_state_t enum {IDLE, BIT, LATCH}
  - default timing constants for 100 MHz
  - PIXEL_BITS = 24
- One natural sub-module, ws_bit_encoder: given a bit value and a start strobe, produces the timed high/low pulse and an end-of-bit strobe. The FSM, shifter and holding register stay in ws_pixel_tx.

Test Plan (bench parameters T0H=2, T1H=4, TBIT=6, TRESET=20):
- Single pixel 24'h800001 with last=1 → o_serial pulses are 4,2×22,4 high cycles, each in a 6-cycle period. Then 20 low cycles, o_frame_done at cycle 144+20, o_busy low afterwards.
- Two pixels 24'hAAAAAA and 24'h555555, source always valid → no gap between bit 0 of pixel 1 and bit 23 of pixel 2. 48 bit periods, then the latch gap.
- Loopback into top_led (DEBOUNCEWIDTH=0, CWIDTH=0):
  - Frame 24'h123456, 24'hABCDEF → o_led_data=24'h123456 after the latch.
  - top_led o_serial carries 24'hABCDEF.
- Underrun: one pixel with last=0, then no valid → o_underrun pulses once at the end of bit 0, followed by a 20-cycle low and o_frame_done.
- Reset asserted in cycle 3 of a '1' bit → o_serial=0 on the next edge, o_ready=1, o_busy=0. A new pixel sent afterwards is encoded correctly from bit 23.
- Backpressure: source holds valid with o_ready low → no word lost or duplicated across 4 pixels. Accepting during LATCH starts the new frame only after o_frame_done.
